scan_sequencer: RTL and testbench

- Upstream address generator for the 6-to-64 one-hot decoder.
- Steps a 6-bit channel index through a programmable range, holding each channel for a programmable number of cycles.
- Produces `addr` plus an enable qualifier that gates the decoder output.
- Supports single-shot and continuous (wrap-around) scanning, ascending or descending.

---
 rtl/scan_pkg.sv | 6 +
 rtl/dwell_counter.sv | 15 +
 rtl/scan_sequencer.sv | 73 +++++++
 tb/tb_scan_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared widths and FSM state type for the scan sequencer
package scan_pkg;
  localparam int AW = 6;
  localparam int DW = 8;
  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts held cycles; in clk/reset/clear/limit, out tick when count==limit, then self-clears
module dwell_counter
  import scan_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [DW-1:0] limit,
  output logic          tick
);
  logic [DW-1:0] count;
  assign tick = !clear && count == limit;
  always_ff @(posedge clk)
    count <= (reset || clear || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps addr over first..last holding dwell+1 cycles each; in start/stop/continuous/first/last/dwell, out addr/en/busy/wrap/done
module scan_sequencer
  import scan_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  input  logic [DW-1:0] dwell,
  output logic [AW-1:0] addr,
  output logic          en,
  output logic          busy,
  output logic          wrap,
  output logic          done
);
  state_t state;
  logic [AW-1:0] first_q, last_q, step;
  logic [DW-1:0] dwell_q;
  logic cont_q, up_q, tick;
  assign step = up_q ? addr + 1'b1 : addr - 1'b1;
  dwell_counter u_dwell (
    .clk(clk),
    .reset(reset),
    .clear(state != SCAN),
    .limit(dwell_q),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !stop) begin
          state   <= SCAN;
          first_q <= first;
          last_q  <= last;
          dwell_q <= dwell;
          cont_q  <= continuous;
          up_q    <= (first <= last);
          addr    <= first;
          en      <= 1'b1;
          busy    <= 1'b1;
        end
        SCAN: if (stop || (tick && addr == last_q && !cont_q)) begin
          state <= FINISH;
          en    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (tick) begin
          addr <= (addr == last_q) ? first_q : step;
          wrap <= (addr == last_q);
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: randomized scans checked against a timeline model of the scan rules
module tb_scan_sequencer;
  import scan_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [AW-1:0] first = '0, last = '0, addr;
  logic [DW-1:0] dwell = '0;
  logic en, busy, wrap, done;
  int total = 0, bad = 0;
  int m_f, m_l, m_d;
  bit m_c;
  scan_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .first(first), .last(last), .dwell(dwell),
    .addr(addr), .en(en), .busy(busy), .wrap(wrap), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] model(input int k);
    int n, hold, idx;
    bit up;
    up = m_f <= m_l;
    n = up ? m_l - m_f + 1 : m_f - m_l + 1;
    hold = m_d + 1;
    if (!m_c && k >= n * hold) return {6'(m_l), 3'b000, k == n * hold};
    idx = (k / hold) % n;
    return {6'(up ? m_f + idx : m_f - idx), 2'b11, m_c && k > 0 && k % (n * hold) == 0, 1'b0};
  endfunction
  task automatic run_scan(input string name, input int f, input int l, input int d, input bit c,
                          input int ncyc, input int stop_k, input bit noise);
    logic [5:0] held;
    logic [63:0] dec, dec_exp;
    m_f = f; m_l = l; m_d = d; m_c = c;
    first = 6'(f); last = 6'(l); dwell = 8'(d); continuous = c; start = 1'b1;
    held = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      logic [9:0] exp;
      exp = (stop_k >= 0 && k > stop_k) ? {held, 3'b000, k == stop_k + 1} : model(k);
      total++;
      if ({addr, en, busy, wrap, done} !== exp)
        begin bad++; $display("FAIL %s k=%0d got addr=%0d en=%b busy=%b wrap=%b done=%b want addr=%0d en=%b busy=%b wrap=%b done=%b",
          name, k, addr, en, busy, wrap, done, exp[9:4], exp[3], exp[2], exp[1], exp[0]); end
      dec = en ? 64'd1 << addr : 64'd0;
      dec_exp = exp[3] ? 64'd1 << exp[9:4] : 64'd0;
      total++;
      if (dec !== dec_exp)
        begin bad++; $display("FAIL %s_decode k=%0d got %h want %h", name, k, dec, dec_exp); end
      if (k == stop_k) held = exp[9:4];
      stop = (k == stop_k);
      if (noise) begin
        first = 6'($urandom); last = 6'($urandom); dwell = 8'($urandom); continuous = 1'($urandom);
        start = exp[3] && k != stop_k && $urandom_range(0, 2) == 0;
      end
      @(posedge clk); #1;
      stop = 1'b0; start = 1'b0;
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); stop = 1'($urandom); continuous = 1'($urandom);
      first = 6'($urandom); last = 6'($urandom); dwell = 8'($urandom);
      @(posedge clk); #1;
      total++;
      if ({addr, en, busy, wrap, done} !== 10'd0)
        begin bad++; $display("FAIL reset cyc=%0d got %b want 0", i, {addr, en, busy, wrap, done}); end
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    run_scan("single", 2, 5, 1, 1'b0, 11, -1, 1'b0);
  endtask
  task automatic test_desc_wrap();
    run_scan("desc_wrap", 63, 60, 0, 1'b1, 14, 9, 1'b0);
  endtask
  task automatic test_same_channel();
    run_scan("same_ch", 7, 7, 3, 1'b1, 20, 13, 1'b1);
  endtask
  task automatic test_start_stop_reset();
    first = 6'd3; last = 6'd9; dwell = 8'd0; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({en, busy, done} !== 3'b000)
        begin bad++; $display("FAIL start_stop cyc=%0d got en/busy/done=%b want 000", i, {en, busy, done}); end
      @(posedge clk); #1;
    end
    first = 6'd10; last = 6'd30; dwell = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({addr, en, busy} !== {6'd10, 2'b11})
      begin bad++; $display("FAIL mid_start got addr=%0d en=%b busy=%b want 10 1 1", addr, en, busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({addr, en, busy, wrap, done} !== 10'd0)
        begin bad++; $display("FAIL mid_reset cyc=%0d got %b want 0", i, {addr, en, busy, wrap, done}); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_full_range();
    run_scan("full_up", 0, 63, 0, 1'b0, 67, -1, 1'b0);
    run_scan("full_down", 63, 0, 0, 1'b0, 67, -1, 1'b0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int f, l, d, n, len, sk;
      bit c;
      f = $urandom_range(0, 63); l = $urandom_range(0, 63); d = $urandom_range(0, 3);
      c = 1'($urandom);
      n = f <= l ? l - f + 1 : f - l + 1;
      len = n * (d + 1);
      if (c) sk = $urandom_range(0, 40);
      else sk = $urandom_range(0, 1) ? $urandom_range(0, len - 1) : -1;
      run_scan("random", f, l, d, c, sk >= 0 ? sk + 3 : len + 2, sk, 1'b1);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_desc_wrap();
    test_same_channel();
    test_start_stop_reset();
    test_full_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
